// File: rtl/param_shift_register.sv
// Parametrised shift register with five shift modes and an automatic N-step
// sequencer (Start/Busy/Done). Optional Abort input under PARAM_SHREG_ABORT_EN.
module param_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Shift_En,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  input  logic [2:0]       Mode,
  input  logic             Shift_In,
`ifdef PARAM_SHREG_ABORT_EN
  input  logic             Abort,
`endif
  output logic [WIDTH-1:0] Data_Out,
  output logic             Shift_Out,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               sout_q, sout_d;
  logic [2:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_clamped;
  logic [WIDTH:0]     live_step;
  logic [WIDTH:0]     seq_step;

  // Returns {bit shifted out, new register value}; modes 101-111 fall to logical right.
  function automatic logic [WIDTH:0] shift_step(input logic [2:0]       md,
                                                input logic [WIDTH-1:0] d,
                                                input logic             sin);
    case (md)
      3'b001:  shift_step = {d[WIDTH-1], d[WIDTH-2:0], sin};
      3'b010:  shift_step = {d[0], d[0], d[WIDTH-1:1]};
      3'b011:  shift_step = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      3'b100:  shift_step = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      default: shift_step = {d[0], sin, d[WIDTH-1:1]};
    endcase
  endfunction

  assign live_step   = shift_step(Mode, data_q, Shift_In);
  assign seq_step    = shift_step(mode_q, data_q, Shift_In);
  assign cnt_clamped = (Count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : Count;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d = state_q;
    data_d  = data_q;
    sout_d  = sout_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mode_d  = Mode;
          cnt_d   = cnt_clamped;
          state_d = (cnt_clamped == '0) ? S_FINISH : S_SHIFT;
        end else if (Load) begin
          data_d = D;
        end else if (Shift_En) begin
          {sout_d, data_d} = live_step;
        end
      end

      S_SHIFT: begin
`ifdef PARAM_SHREG_ABORT_EN
        if (Abort) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else
`endif
        begin
          {sout_d, data_d} = seq_step;
          cnt_d            = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = S_FINISH;
        end
      end

      S_FINISH: state_d = S_IDLE;

      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      sout_q  <= 1'b0;
      mode_q  <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Data_Out  = data_q;
  assign Shift_Out = sout_q;
  assign Busy      = (state_q == S_SHIFT);
  assign Done      = (state_q == S_FINISH);

endmodule

// File: tb/tb_param_shift_register.sv
// Randomised self-checking bench for param_shift_register (WIDTH=8) against a
// transaction-level reference model; covers Abort when PARAM_SHREG_ABORT_EN is set.
module tb_param_shift_register;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load;
  logic [W-1:0]  d;
  logic          shift_en;
  logic          start;
  logic [CW-1:0] count;
  logic [2:0]    mode;
  logic          shift_in;
`ifdef PARAM_SHREG_ABORT_EN
  logic          abort;
`endif
  logic [W-1:0]  data_out;
  logic          shift_out;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0]  m_data;
  logic          m_sout;

  param_shift_register #(.WIDTH(W)) dut (
    .Clk      (clk),
    .Reset_n  (reset_n),
    .Load     (load),
    .D        (d),
    .Shift_En (shift_en),
    .Start    (start),
    .Count    (count),
    .Mode     (mode),
    .Shift_In (shift_in),
`ifdef PARAM_SHREG_ABORT_EN
    .Abort    (abort),
`endif
    .Data_Out (data_out),
    .Shift_Out(shift_out),
    .Busy     (busy),
    .Done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One shift applied to the model with plain integer arithmetic.
  function automatic void ref_shift(input logic [2:0] md, input logic sin);
    int unsigned v;
    v = int'(m_data);
    case (md)
      3'd1: begin m_sout = m_data[W-1]; m_data = W'((v << 1) | int'(sin)); end
      3'd2: begin m_sout = m_data[0];   m_data = W'((v >> 1) | (v << (W - 1))); end
      3'd3: begin m_sout = m_data[W-1]; m_data = W'((v << 1) | (v >> (W - 1))); end
      3'd4: begin m_sout = m_data[0];   m_data = W'($signed(m_data) >>> 1); end
      default: begin
        m_sout = m_data[0];
        m_data = W'((v >> 1) | (int'(sin) << (W - 1)));
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    load     = 1'b0;
    shift_en = 1'b0;
    start    = 1'b0;
`ifdef PARAM_SHREG_ABORT_EN
    abort    = 1'b0;
`endif
  endtask

  task automatic check_out(input string tag);
    check({tag, "_data"}, 32'(data_out), 32'(m_data));
    check({tag, "_sout"}, 32'(shift_out), 32'(m_sout));
  endtask

  task automatic do_load(input logic [W-1:0] val);
    load = 1'b1;
    d    = val;
    tick();
    load   = 1'b0;
    m_data = val;
    check_out("load");
  endtask

  task automatic do_step(input logic [2:0] md, input logic sin);
    shift_en = 1'b1;
    mode     = md;
    shift_in = sin;
    tick();
    shift_en = 1'b0;
    ref_shift(md, sin);
    check_out("step");
    check("step_busy", 32'(busy), 32'd0);
  endtask

  // Start an N-step sequence; sin_fix < 0 means random Shift_In per cycle.
  task automatic run_seq(input logic [2:0] md, input int cnt, input int sin_fix,
                         input bit disturb, input int abort_at);
    int n;
    n = (cnt > W) ? W : cnt;
    start    = 1'b1;
    mode     = md;
    count    = CW'(cnt);
    load     = 1'($urandom_range(1));
    d        = W'($urandom);
    shift_en = 1'($urandom_range(1));
    tick();
    quiet_inputs();
    for (int i = 1; i <= n; i++) begin
      check("seq_busy", 32'(busy), 32'd1);
      check("seq_done_lo", 32'(done), 32'd0);
      shift_in = (sin_fix < 0) ? 1'($urandom_range(1)) : 1'(sin_fix);
      mode     = 3'($urandom);
      count    = CW'($urandom);
      if (disturb) begin
        load     = 1'b1;
        d        = '1;
        start    = 1'b1;
        shift_en = 1'b1;
      end
`ifdef PARAM_SHREG_ABORT_EN
      if (i == abort_at) begin
        abort = 1'b1;
        tick();
        quiet_inputs();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check_out("abort");
        tick();
        check("abort_no_done", 32'(done), 32'd0);
        check_out("abort_hold");
        return;
      end
`endif
      tick();
      ref_shift(md, shift_in);
    end
    quiet_inputs();
    // Start held through the FINISH edge must not be accepted.
    start = 1'b1;
    count = CW'(3);
    check("fin_busy", 32'(busy), 32'd0);
    check("fin_done", 32'(done), 32'd1);
    check_out("fin");
    tick();
    start = 1'b0;
    check("post_busy", 32'(busy), 32'd0);
    check("post_done", 32'(done), 32'd0);
    check_out("post");
  endtask

  initial begin
    reset_n  = 1'b0;
    d        = '0;
    count    = '0;
    mode     = 3'b000;
    shift_in = 1'b0;
    quiet_inputs();
    m_data   = '0;
    m_sout   = 1'b0;
    #12;
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_sout", 32'(shift_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Arithmetic right by 3
    do_load(8'hB4);
    run_seq(3'b100, 3, 0, 1'b0, 0);
    check("t2_data", 32'(data_out), 32'hF6);
    check("t2_sout", 32'(shift_out), 32'd1);

    // Rotate left, Count clamped to WIDTH
    do_load(8'h81);
    run_seq(3'b011, 12, 0, 1'b0, 0);
    check("t3_data", 32'(data_out), 32'h81);

    // Count = 0: Done next cycle, no shift
    do_load(8'h5A);
    run_seq(3'b000, 0, 0, 1'b0, 0);
    check("t4_data", 32'(data_out), 32'h5A);

    // Load/Start/Shift_En during Busy ignored
    do_load(8'h0F);
    run_seq(3'b001, 4, 0, 1'b1, 0);
    check("t5_data", 32'(data_out), 32'hF0);

`ifdef PARAM_SHREG_ABORT_EN
    do_load(8'h80);
    run_seq(3'b000, 6, 0, 1'b0, 3);
    check("t6_data", 32'(data_out), 32'h20);
`endif

    // Single steps in every mode code, including the aliases
    do_load(8'hC3);
    for (int m = 0; m < 8; m++) do_step(3'(m), 1'(m & 1));

    // Asynchronous reset mid-sequence
    do_load(8'hA5);
    start = 1'b1;
    mode  = 3'b011;
    count = CW'(8);
    tick();
    start = 1'b0;
    check("t1_busy_pre", 32'(busy), 32'd1);
    check("t1_data_pre", 32'(data_out), 32'hA5);
    #2;
    reset_n = 1'b0;
    #1;
    m_data = '0;
    m_sout = 1'b0;
    check("t1_data", 32'(data_out), 32'd0);
    check("t1_sout", 32'(shift_out), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1_no_done", 32'(done), 32'd0);
      check("t1_no_busy", 32'(busy), 32'd0);
    end
    check_out("t1_after");

    // Randomised mix of operations
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(4))
        0: do_load(W'($urandom));
        1: do_step(3'($urandom), 1'($urandom_range(1)));
        2: run_seq(3'($urandom), int'($urandom_range(15)), -1,
                   1'($urandom_range(1)), int'($urandom_range(9)));
        3: begin
          mode     = 3'($urandom);
          shift_in = 1'($urandom_range(1));
          tick();
          check_out("hold");
          check("hold_busy", 32'(busy), 32'd0);
          check("hold_done", 32'(done), 32'd0);
        end
        default: begin
          load     = 1'b1;
          shift_en = 1'b1;
          d        = W'($urandom);
          mode     = 3'($urandom);
          tick();
          quiet_inputs();
          m_data = d;
          check_out("load_prio");
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_shift_register.md
Name: param_shift_register

Overview:
Parametrised successor to the team's 8-bit right-shift register. Adds a WIDTH parameter, five shift modes, and an automatic multi-step shift sequencer with a Start/Busy/Done handshake. Single-step shifting remains available. Intended as the accumulator/operand register in multiplier and serial-datapath labs, where a controller requests "shift N times" and does not toggle Shift_En every cycle.

Parameters:
WIDTH, 8, register width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), width of the Count port and the internal step counter (derived; do not override)

Ports:
Clk  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
Load  input  1  parallel load of D (honoured only when idle)
D  input  WIDTH  parallel load data
Shift_En  input  1  single-step shift (honoured only when idle)
Start  input  1  begin an automatic Count-step shift sequence (honoured only when idle)
Count  input  CNT_W  number of steps, sampled on the Start cycle
Mode  input  3  000 logical right (Shift_In enters MSB); 001 logical left (Shift_In enters LSB); 010 rotate right; 011 rotate left; 100 arithmetic right (MSB replicated); 101–111 treated as 000
Shift_In  input  1  serial input bit for modes 000/001
Data_Out  output  WIDTH  register contents
Shift_Out  output  1  bit most recently shifted out (LSB for right modes, MSB for left modes)
Busy  output  1  high while the sequencer is shifting
Done  output  1  one-cycle pulse when a Start sequence completes

Behaviour:
- Reset_n low (asynchronous): Data_Out=0, Shift_Out=0, Busy=0, Done=0, FSM=IDLE, step counter=0. Takes effect immediately, including mid-sequence; the sequence is abandoned and Done is not produced.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE priority, highest first: Start > Load > Shift_En > hold.
- Start in IDLE: latch Mode and min(Count, WIDTH) into internal registers. Count values above WIDTH clamp to WIDTH.
  - Latched count = 0: go to FINISH with no shift.
  - Otherwise: go to SHIFT. Busy=1 from the next cycle.
- SHIFT: one shift per cycle using the latched Mode. Shift_In is sampled live each cycle. Counter decrements each cycle. After the final shift, go to FINISH. An N-step sequence spends exactly N cycles in SHIFT.
- FINISH: Busy=0, Done=1 for exactly one cycle, then IDLE. Start is first accepted in the cycle after Done.
- Latency: a Start accepted at edge k with Count=N≥1 gives Busy high for edges k+1..k+N and Done high in the cycle after the final shift.
- While Busy or in FINISH, Load, Shift_En, Start and changes to Mode/Count are ignored.
- Shift_En in IDLE: one shift using the live Mode. Shift_Out updates on every shift and holds otherwise.
- Load does not change Shift_Out.
- All register updates are synchronous to the rising edge of Clk, except reset.

Optional Feature:
Macro PARAM_SHREG_ABORT_EN.
- Defined: adds input port Abort (1 bit). Abort high in SHIFT stops shifting at that edge (no shift performed that cycle), keeps the partial Data_Out, and moves to IDLE with Busy=0 and no Done pulse. Abort is ignored in IDLE and FINISH.
- Undefined: no Abort port; every sequence runs to completion.

Test Plan:
1. Reset_n=0 mid-sequence (Data_Out=8'hA5, Busy=1) -> Data_Out=0, Busy=0, Done=0 immediately; no Done pulse follows.
2. Load D=8'hB4, then Start Mode=100, Count=3 -> Busy high for 3 cycles, Data_Out=8'hF6, Shift_Out=1, Done pulses once.
3. Load 8'h81, Start Mode=011, Count=12 (clamped to 8) -> Busy exactly 8 cycles, Data_Out=8'h81 at Done.
4. Start Count=0 -> no Busy cycle, Done high in the next cycle, Data_Out unchanged.
5. During Busy, assert Load D=8'hFF and Start -> both ignored. Result matches an undisturbed run (Load 8'h0F, Mode=001, Shift_In=0, Count=4 -> 8'hF0).
6. (PARAM_SHREG_ABORT_EN) Load 8'h80, Start Mode=000, Shift_In=0, Count=6, Abort on the 3rd SHIFT cycle -> Data_Out=8'h20, Busy=0, no Done.
